prog_moore_fsm: RTL

Table-driven Moore FSM with one-hot state. Generalises our hand-coded one-hot controllers to a parametrised number of states, inputs, and prioritised transition rules, all loaded at run time through a configuration port. It drives the same controller slot, adds a deterministic hold when no rule matches, and provides a state-dwell counter and a transition pulse.

---
 rtl/prog_moore_fsm_pkg.sv | 51 +++++
 rtl/prog_moore_fsm_rule_sel.sv | 58 +++++
 rtl/prog_moore_fsm.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/prog_moore_fsm_pkg.sv
// prog_moore_fsm_pkg
// Shared definitions for the table-driven Moore FSM.
//   - Rule word layout helpers. The word is {valid, src, dst, mask, value},
//     MSB first, so value sits at bit 0.
//   - idx_w(): index width that never collapses to zero bits.
//   - onehot(): one-hot constant from a state index.
//   - fsm_evt_e: per-cycle event class used by the next-state logic.
package prog_moore_fsm_pkg;

  localparam int MAX_STATES = 64;

  // What the FSM does on a given edge, in priority order clr > freeze > step.
  typedef enum logic [1:0] {
    EV_STEP   = 2'd0,
    EV_FREEZE = 2'd1,
    EV_CLR    = 2'd2
  } fsm_evt_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int VALUE_LSB();
    return 0;
  endfunction

  function automatic int MASK_LSB(input int num_in);
    return num_in;
  endfunction

  function automatic int DST_LSB(input int num_in);
    return 2 * num_in;
  endfunction

  function automatic int SRC_LSB(input int sw, input int num_in);
    return sw + 2 * num_in;
  endfunction

  function automatic int VALID_BIT(input int sw, input int num_in);
    return 2 * sw + 2 * num_in;
  endfunction

  function automatic int rule_w(input int sw, input int num_in);
    return 1 + 2 * sw + 2 * num_in;
  endfunction

  function automatic logic [MAX_STATES-1:0] onehot(input int idx);
    return {{(MAX_STATES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prog_moore_fsm_rule_sel.sv
// prog_moore_fsm_rule_sel
// Combinational priority selector over the transition-rule table.
// Ports:
//   rules     - full rule table (registered in the parent)
//   state_idx - binary index of the current state
//   in        - condition inputs
//   hit       - at least one rule matches
//   dst_idx   - destination of the lowest-index matching rule (0 if no hit)
module prog_moore_fsm_rule_sel
  import prog_moore_fsm_pkg::*;
#(
  parameter int NUM_STATES = 4,
  parameter int NUM_IN     = 3,
  parameter int NUM_RULES  = 8,
  parameter int SW         = idx_w(NUM_STATES),
  parameter int RULE_W     = rule_w(SW, NUM_IN)
) (
  input  logic [RULE_W-1:0] rules [NUM_RULES],
  input  logic [SW-1:0]     state_idx,
  input  logic [NUM_IN-1:0] in,
  output logic              hit,
  output logic [SW-1:0]     dst_idx
);

  localparam int VB = VALID_BIT(SW, NUM_IN);
  localparam int SL = SRC_LSB(SW, NUM_IN);
  localparam int DL = DST_LSB(NUM_IN);
  localparam int ML = MASK_LSB(NUM_IN);
  localparam int VL = VALUE_LSB();
  localparam logic [SW:0] DST_LIMIT = (SW+1)'(NUM_STATES);

  logic [NUM_RULES-1:0] match;

  // A source index out of range can never equal the (always legal) current
  // index, so only the destination needs an explicit range check.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      match[i] = rules[i][VB]
              && (rules[i][SL +: SW] == state_idx)
              && ({1'b0, rules[i][DL +: SW]} < DST_LIMIT)
              && (((in ^ rules[i][VL +: NUM_IN]) & rules[i][ML +: NUM_IN]) == '0);
    end
  end

  // Scanning from the top down lets the lowest-index match overwrite the rest.
  always_comb begin
    hit     = 1'b0;
    dst_idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        dst_idx = rules[i][DL +: SW];
      end
    end
  end

endmodule

// File: rtl/prog_moore_fsm.sv
// prog_moore_fsm
// Run-time programmable Moore FSM with a one-hot state register.
// Ports:
//   clk, rst_b             - clock, asynchronous active-low reset
//   en                     - advance enable (0 freezes state and dwell)
//   clr                    - synchronous return to RST_STATE, tables kept
//   in                     - condition inputs
//   rule_we/addr/wdata     - rule table write port
//   outv_we/addr/wdata     - per-state output table write port
//   state, state_idx       - one-hot and binary current state
//   out                    - output table entry of the current state
//   dwell                  - saturating cycles spent in current state
//   trans                  - one-cycle pulse when a new state becomes visible
module prog_moore_fsm
  import prog_moore_fsm_pkg::*;
#(
  parameter int NUM_STATES = 4,
  parameter int NUM_IN     = 3,
  parameter int NUM_RULES  = 8,
  parameter int OUT_W      = 1,
  parameter int CNT_W      = 8,
  parameter int RST_STATE  = 0,
  localparam int SW        = idx_w(NUM_STATES),
  localparam int AW        = idx_w(NUM_RULES),
  localparam int RULE_W    = rule_w(SW, NUM_IN)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  en,
  input  logic                  clr,
  input  logic [NUM_IN-1:0]     in,
  input  logic                  rule_we,
  input  logic [AW-1:0]         rule_addr,
  input  logic [RULE_W-1:0]     rule_wdata,
  input  logic                  outv_we,
  input  logic [SW-1:0]         outv_addr,
  input  logic [OUT_W-1:0]      outv_wdata,
  output logic [NUM_STATES-1:0] state,
  output logic [SW-1:0]         state_idx,
  output logic [OUT_W-1:0]      out,
  output logic [CNT_W-1:0]      dwell,
  output logic                  trans
);

  localparam logic [NUM_STATES-1:0] RST_ONEHOT = NUM_STATES'(onehot(RST_STATE));

  logic [NUM_STATES-1:0] state_q, state_d;
  logic [CNT_W-1:0]      dwell_q, dwell_d;
  logic                  trans_q, trans_d;
  logic [RULE_W-1:0]     rules_q   [NUM_RULES];
  logic [RULE_W-1:0]     rules_d   [NUM_RULES];
  logic [OUT_W-1:0]      out_tbl_q [NUM_STATES];
  logic [OUT_W-1:0]      out_tbl_d [NUM_STATES];

  fsm_evt_e          evt;
  logic              hit;
  logic [SW-1:0]     dst_idx;

  // One-hot to binary; OR-reduction avoids a priority chain.
  always_comb begin
    state_idx = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      state_idx = state_idx | (state_q[i] ? SW'(i) : '0);
    end
  end

  // Output comes only from registered state and table, never from in.
  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      out = out | (state_q[i] ? out_tbl_q[i] : '0);
    end
  end

  prog_moore_fsm_rule_sel #(
    .NUM_STATES (NUM_STATES),
    .NUM_IN     (NUM_IN),
    .NUM_RULES  (NUM_RULES),
    .SW         (SW),
    .RULE_W     (RULE_W)
  ) u_rule_sel (
    .rules     (rules_q),
    .state_idx (state_idx),
    .in        (in),
    .hit       (hit),
    .dst_idx   (dst_idx)
  );

  always_comb begin
    evt = clr ? EV_CLR : (en ? EV_STEP : EV_FREEZE);
  end

  // Next state, dwell and transition pulse. A matching self-loop is treated
  // exactly like a no-match hold so dwell keeps counting.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    trans_d = 1'b0;
    unique case (evt)
      EV_CLR: begin
        state_d = RST_ONEHOT;
        dwell_d = '0;
        trans_d = (state_q != RST_ONEHOT);
      end
      EV_FREEZE: begin
        trans_d = 1'b0;
      end
      EV_STEP: begin
        if (hit && (dst_idx != state_idx)) begin
          for (int i = 0; i < NUM_STATES; i++) begin
            state_d[i] = (dst_idx == SW'(i));
          end
          dwell_d = '0;
          trans_d = 1'b1;
        end else if (dwell_q != {CNT_W{1'b1}}) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Table updates. Address compares against each legal slot make out-of-range
  // writes fall through naturally; both tables may be written on one edge.
  always_comb begin
    rules_d   = rules_q;
    out_tbl_d = out_tbl_q;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (rule_we && (rule_addr == AW'(i))) begin
        rules_d[i] = rule_wdata;
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      if (outv_we && (outv_addr == SW'(i))) begin
        out_tbl_d[i] = outv_wdata;
      end
    end
  end

  // All state lives here; the rule selector sees only the pre-edge tables.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= RST_ONEHOT;
      dwell_q   <= '0;
      trans_q   <= 1'b0;
      rules_q   <= '{default: '0};
      out_tbl_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      trans_q   <= trans_d;
      rules_q   <= rules_d;
      out_tbl_q <= out_tbl_d;
    end
  end

  assign state = state_q;
  assign dwell = dwell_q;
  assign trans = trans_q;

endmodule
